alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Time-shares the single combinational 4-bit `alu` between two requesters: board switch capture and an auto-test sequencer. It does round-robin arbitration, latches the winner's operands into registers that drive the ALU, waits a fixed settle time, captures the 8-bit result and returns it with a one-cycle acknowledge. It sits between the requesters and the `alu` instance. `rsp_y` feeds the BCD/7-segment display path.

## Interface
- `WAIT_CYC`, default 1: cycles from operand issue to result capture; legal range 1–15.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: synchronous reset, active-low.
- `req0` / `req1`, input, 1: request level from requester 0 / 1.
- `a0`, `b0`, `op0`, input, 4/4/2: requester 0 operands and opcode.
- `a1`, `b1`, `op1`, input, 4/4/2: requester 1 operands and opcode.
- `alu_y`, input, 8: combinational ALU result.
- `alu_a`, `alu_b`, `alu_op`, output, 4/4/2: registered ALU operands.
- `gnt`, output, 2: one-hot grant, held for the whole transaction.
- `ack0` / `ack1`, output, 1: one-cycle completion pulse per requester.
- `rsp_y`, output, 8: captured result, held until the next capture.
- `busy`, output, 1: high whenever state is not IDLE.

## Operation
- State machine states: IDLE, WAIT, ACK.
- IDLE, when any request is high:
  - Select a winner by round-robin.
  - Latch the winner's a/b/op into `alu_a`/`alu_b`/`alu_op`.
  - Set `gnt` to the winner.
  - Load the wait counter with `WAIT_CYC - 1`.
  - Go to WAIT.
- IDLE, no request: stay; all registers hold.
- WAIT: decrement the counter. At 0:
  - `rsp_y <= alu_y`.
  - Set `ack` of the granted requester.
  - Update the last-grant pointer.
  - Go to ACK.
- ACK: clear `ack` and `gnt`, then go to IDLE. Requests are not sampled in ACK.
- Round-robin:
  - If only one request is high, it wins.
  - If both are high, the requester not granted last wins.
  - After reset the last-grant pointer is 1, so requester 0 wins the first tie.
- Operands are sampled once, at grant. Changes to a/b/op or req during WAIT/ACK are ignored.
- A requester dropping req mid-transaction does not abort it; the ack is still issued.
- Req still high in IDLE after its ack is a new request. Requesters must drop req in the ack cycle for single-shot use.
- `rsp_y` is the full 8-bit `alu_y`, unmodified. Truncation for display happens downstream.
- Reset, in any state:
  - Go to IDLE.
  - `gnt = 2'b00`, `ack0 = ack1 = 0`, `busy = 0`.
  - `alu_a = alu_b = 0`, `alu_op = 0`, `rsp_y = 0`.
  - Last-grant pointer = 1, wait counter = 0.
  - An in-flight transaction is dropped with no ack.

## Timing
- Req high at edge k, in IDLE: `alu_*`, `gnt` and `busy` are valid after edge k.
- Capture happens at edge k+WAIT_CYC. `ack` and the new `rsp_y` are visible during cycle k+WAIT_CYC to k+WAIT_CYC+1.
- Idle at edge k+WAIT_CYC+1; earliest next grant is at edge k+WAIT_CYC+2.
- Request-to-ack latency is WAIT_CYC+1 edges.
- Throughput is one operation per WAIT_CYC+2 cycles.
- `ack0` and `ack1` are never high together. `gnt` is never 2'b11.
- `busy` rises with `gnt` and falls one cycle after `ack`.

## Test plan
Bench ALU stub: `alu_y = alu_a + alu_b` when op=00, `alu_a * alu_b` when op=01; WAIT_CYC=1 unless noted.
- Single request: req0 with a0=5, b0=3, op0=00 → `gnt`=01 after 1 edge, `ack0` pulse 1 cycle later, `rsp_y`=8, `ack1` never high.
- Tie after reset: req0 and req1 high together, a1=15, b1=15, op1=01 → requester 0 served first, then requester 1 with `rsp_y`=225 (8'hE1). Grant order is 0,1,0,1 while both are held high.
- Operand change mid-op: WAIT_CYC=3, req1 with 2+2, change b1 to 9 during WAIT → `rsp_y`=4. Ack arrives 4 edges after the request.
- Early req drop: req0 deasserted in the cycle after grant → `ack0` is still issued and `rsp_y` is correct. No second transaction follows.
- Reset mid-operation: rst_n low during WAIT → next cycle all outputs are 0, `busy`=0, and no ack. After release, a tie grants requester 0.
- Back-to-back saturation: both requests held high for 20 cycles, WAIT_CYC=1 → exactly one ack every 3 cycles, alternating 0/1. Each `rsp_y` matches the stub for that requester's operands.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin time-sharing of one combinational 4-bit ALU between two requesters.
// Latency: operands issued at grant, result captured WAIT_CYC edges later, ack one cycle wide.
// Backpressure: one transaction in flight; requests are only sampled in IDLE, others wait.
module alu_share_arbiter #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [1:0] op0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [1:0] op1,
  input  logic [7:0] alu_y,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  output logic [1:0] gnt,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rsp_y,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  // Counter is loaded with WAIT_CYC-1 so that capture lands exactly WAIT_CYC edges after grant.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic [1:0] gnt_q, gnt_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic [7:0] rsp_y_q, rsp_y_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       win1;

  // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
  assign win1 = req1 && (!req0 || !last_q);

  // Next-state and datapath: grant/latch in IDLE, count down and capture in WAIT, release in ACK.
  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    gnt_d    = gnt_q;
    ack0_d   = ack0_q;
    ack1_d   = ack1_q;
    rsp_y_d  = rsp_y_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          alu_a_d  = win1 ? a1 : a0;
          alu_b_d  = win1 ? b1 : b0;
          alu_op_d = win1 ? op1 : op0;
          gnt_d    = win1 ? 2'b10 : 2'b01;
          cnt_d    = CNT_INIT;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_y_d = alu_y;
          ack0_d  = gnt_q[0];
          ack1_d  = gnt_q[1];
          last_d  = gnt_q[1];
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      alu_a_q  <= 4'd0;
      alu_b_q  <= 4'd0;
      alu_op_q <= 2'd0;
      gnt_q    <= 2'b00;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rsp_y_q  <= 8'd0;
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      gnt_q    <= gnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rsp_y_q  <= rsp_y_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;
  assign gnt    = gnt_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rsp_y  = rsp_y_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose: directed checks of the ALU-sharing arbiter with WAIT_CYC=1 and WAIT_CYC=3 instances.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: requests held or dropped explicitly by each scenario.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
  logic [1:0] op0 = 2'd0, op1 = 2'd0;

  // WAIT_CYC=1 instance
  logic [7:0] alu_y;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op, gnt;
  logic       ack0, ack1, busy;
  logic [7:0] rsp_y;

  // WAIT_CYC=3 instance
  logic [7:0] alu_y3;
  logic [3:0] alu_a3, alu_b3;
  logic [1:0] alu_op3, gnt3;
  logic       ack0_3, ack1_3, busy3;
  logic [7:0] rsp_y3;

  int n_tests = 0;
  int n_fail  = 0;
  int n_viol  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WAIT_CYC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .alu_y(alu_y), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .gnt(gnt), .ack0(ack0), .ack1(ack1), .rsp_y(rsp_y), .busy(busy)
  );

  alu_share_arbiter #(.WAIT_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .alu_y(alu_y3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .gnt(gnt3), .ack0(ack0_3), .ack1(ack1_3), .rsp_y(rsp_y3), .busy(busy3)
  );

  // ALU stubs: op 00 adds, op 01 multiplies
  always_comb begin
    alu_y = 8'd0;
    if (alu_op == 2'd0) alu_y = {4'd0, alu_a} + {4'd0, alu_b};
    else if (alu_op == 2'd1) alu_y = {4'd0, alu_a} * {4'd0, alu_b};
  end

  always_comb begin
    alu_y3 = 8'd0;
    if (alu_op3 == 2'd0) alu_y3 = {4'd0, alu_a3} + {4'd0, alu_b3};
    else if (alu_op3 == 2'd1) alu_y3 = {4'd0, alu_a3} * {4'd0, alu_b3};
  end

  // Illegal output combinations on either instance
  always @(negedge clk) begin
    if ((ack0 && ack1) || (gnt == 2'b11) || (ack0_3 && ack1_3) || (gnt3 == 2'b11))
      n_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One WAIT_CYC=1 transaction on u_dut with requests already set up
  task automatic txn(input string tag, input logic [1:0] g, input logic [7:0] y);
    tick();
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_ack"}, 32'({ack1, ack0}), 32'(g));
    chk({tag, "_rsp"}, 32'(rsp_y), 32'(y));
    tick();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'({ack1, ack0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops", 32'({alu_a, alu_b, alu_op}), 32'd0);
    chk("rst_rsp", 32'(rsp_y), 32'd0);

    // Single request: 5+3
    a0 = 4'd5; b0 = 4'd3; op0 = 2'd0; req0 = 1'b1;
    txn("single", 2'b01, 8'd8);
    req0 = 1'b0;
    chk("single_a", 32'(alu_a), 32'd5);
    chk("single_hold", 32'(rsp_y), 32'd8);

    // Tie after reset: order 0,1,0,1
    do_reset();
    a0 = 4'd1; b0 = 4'd2; op0 = 2'd0;
    a1 = 4'd15; b1 = 4'd15; op1 = 2'd1;
    req0 = 1'b1; req1 = 1'b1;
    txn("tie1", 2'b01, 8'd3);
    txn("tie2", 2'b10, 8'hE1);
    txn("tie3", 2'b01, 8'd3);
    txn("tie4", 2'b10, 8'hE1);
    req0 = 1'b0; req1 = 1'b0;

    // Operand change mid-op on WAIT_CYC=3 instance
    do_reset();
    a1 = 4'd2; b1 = 4'd2; op1 = 2'd0; req1 = 1'b1;
    tick();
    chk("w3_gnt", 32'(gnt3), 32'b10);
    b1 = 4'd9;
    tick();
    chk("w3_noack1", 32'(ack1_3), 32'd0);
    chk("w3_b_held", 32'(alu_b3), 32'd2);
    tick();
    chk("w3_noack2", 32'(ack1_3), 32'd0);
    tick();
    chk("w3_ack", 32'({ack1_3, ack0_3}), 32'b10);
    chk("w3_rsp", 32'(rsp_y3), 32'd4);
    req1 = 1'b0;
    tick();
    chk("w3_idle", 32'(busy3), 32'd0);

    // Early request drop
    do_reset();
    a0 = 4'd7; b0 = 4'd6; op0 = 2'd1; req0 = 1'b1;
    tick();
    chk("drop_gnt", 32'(gnt), 32'b01);
    req0 = 1'b0;
    tick();
    chk("drop_ack", 32'(ack0), 32'd1);
    chk("drop_rsp", 32'(rsp_y), 32'd42);
    tick();
    tick();
    tick();
    chk("drop_no_second_gnt", 32'(gnt), 32'd0);
    chk("drop_no_second_busy", 32'(busy), 32'd0);

    // Reset mid-operation on WAIT_CYC=3 instance
    do_reset();
    a0 = 4'd3; b0 = 4'd4; op0 = 2'd0; req0 = 1'b1;
    tick();
    chk("rmid_busy", 32'(busy3), 32'd1);
    chk("rmid_a", 32'(alu_a3), 32'd3);
    rst_n = 1'b0;
    req0  = 1'b0;
    tick();
    chk("rmid_outs", 32'({alu_a3, alu_b3, alu_op3, gnt3, ack1_3, ack0_3}), 32'd0);
    chk("rmid_rsp", 32'(rsp_y3), 32'd0);
    chk("rmid_busy0", 32'(busy3), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rmid_noack", 32'({ack1_3, ack0_3}), 32'd0);
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("rmid_tie_gnt", 32'(gnt3), 32'b01);
    req0 = 1'b0; req1 = 1'b0;

    // Back-to-back saturation on WAIT_CYC=1 instance
    do_reset();
    a0 = 4'd4; b0 = 4'd9; op0 = 2'd1;
    a1 = 4'd10; b1 = 4'd11; op1 = 2'd0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      tick();
      chk("sat_ack0", 32'(ack0), 32'((i % 3 == 2) && ((i / 3) % 2 == 0)));
      chk("sat_ack1", 32'(ack1), 32'((i % 3 == 2) && ((i / 3) % 2 == 1)));
      if (i % 3 == 2)
        chk("sat_rsp", 32'(rsp_y), ((i / 3) % 2 == 0) ? 32'd36 : 32'd21);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    chk("mutex_onehot", 32'(n_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
